// File: rtl/uart_rx_fifo.sv
// Receive FIFO for uart_top: stores each character with its {break, framing, parity} flags.
// Latency: first-word-fall-through, so a push on edge N is visible on rd_data/count after edge N.
// Backpressure: a push while full with no pop is dropped and reported through overrun/overrun_sticky.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int TOUT_W = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        wr_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        rd_err,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  input  logic [1:0]        trig_sel,
  output logic              trig_hit,
  input  logic [TOUT_W-1:0] tout_cycles,
  output logic              timeout,
  output logic              err_pending,
  output logic              overrun,
  output logic              overrun_sticky,
  input  logic              ovr_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W+2:0] mem [DEPTH];
  logic [DATA_W+2:0] head;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CNT_W-1:0]  err_cnt;
  logic [TOUT_W-1:0] tcnt;
  logic [CNT_W-1:0]  trig_lvl;
  logic              push;
  logic              pop;
  logic              drop;
  logic              err_inc;
  logic              err_dec;

  // Accepted push/pop and dropped push; a flush discards both strobes.
  always_comb begin
    pop     = rd_en && !empty && !fifo_clr;
    push    = wr_en && !fifo_clr && (!full || rd_en);
    drop    = wr_en && !fifo_clr && full && !rd_en;
    err_inc = push && (|wr_err);
    err_dec = pop && (|rd_err);
  end

  // Head entry is presented directly from storage (no read latency).
  always_comb begin
    head    = mem[rd_ptr];
    rd_data = head[DATA_W-1:0];
    rd_err  = head[DATA_W+2:DATA_W];
  end

  // Storage write; contents are not reset, pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {wr_err, wr_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  // Number of stored entries carrying any error flag.
  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      err_cnt <= '0;
    end else if (err_inc && !err_dec) begin
      err_cnt <= err_cnt + 1'b1;
    end else if (err_dec && !err_inc) begin
      err_cnt <= err_cnt - 1'b1;
    end
  end

  // Idle counter since last FIFO activity, clamped at tout_cycles so it can hold on the compare value.
  always_ff @(posedge clk) begin
    if (rst || fifo_clr || push || pop || empty) begin
      tcnt <= '0;
    end else if (tcnt >= tout_cycles) begin
      tcnt <= tout_cycles;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // One-cycle drop pulse plus latched flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun        <= 1'b0;
      overrun_sticky <= 1'b0;
    end else begin
      overrun <= drop;
      if (drop) begin
        overrun_sticky <= 1'b1;
      end else if (ovr_clr) begin
        overrun_sticky <= 1'b0;
      end
    end
  end

  // Trigger level decode; the smallest level is 1 so an empty FIFO never triggers.
  always_comb begin
    trig_lvl = CNT_W'(1);
    case (trig_sel)
      2'd0: trig_lvl = CNT_W'(1);
      2'd1: trig_lvl = CNT_W'(DEPTH / 4);
      2'd2: trig_lvl = CNT_W'(DEPTH / 2);
      2'd3: trig_lvl = CNT_W'(DEPTH - 2);
      default: trig_lvl = CNT_W'(1);
    endcase
  end

  // Status flags derived from registered state.
  always_comb begin
    empty       = (count == '0);
    full        = (count == CNT_W'(DEPTH));
    trig_hit    = (count >= trig_lvl);
    err_pending = (err_cnt != '0);
    timeout     = (tout_cycles != '0) && !empty && (tcnt == tout_cycles);
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int TOUT_W = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        wr_err;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        rd_err;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic [1:0]        trig_sel;
  logic              trig_hit;
  logic [TOUT_W-1:0] tout_cycles;
  logic              timeout;
  logic              err_pending;
  logic              overrun;
  logic              overrun_sticky;
  logic              ovr_clr;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TOUT_W(TOUT_W)) dut (
    .clk(clk), .rst(rst), .fifo_clr(fifo_clr),
    .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
    .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
    .empty(empty), .full(full), .count(count),
    .trig_sel(trig_sel), .trig_hit(trig_hit),
    .tout_cycles(tout_cycles), .timeout(timeout),
    .err_pending(err_pending), .overrun(overrun),
    .overrun_sticky(overrun_sticky), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model: a queue of {err, data} entries plus a few flags.
  logic [10:0] q[$];
  bit          m_sticky = 1'b0;
  bit          m_ovr    = 1'b0;
  int          m_idle   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_trig_lvl(input logic [1:0] sel);
    case (sel)
      2'd0: return 1;
      2'd1: return DEPTH / 4;
      2'd2: return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  function automatic bit m_err_pending();
    foreach (q[i]) if (q[i][10:8] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  // Model update at each active edge from the inputs presented for that cycle.
  always @(posedge clk) begin
    bit was_empty, was_full, do_pop, do_push, do_drop;
    if (rst) begin
      q.delete();
      m_sticky = 1'b0;
      m_ovr    = 1'b0;
      m_idle   = 0;
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      do_pop    = !fifo_clr && rd_en && !was_empty;
      do_push   = !fifo_clr && wr_en && (!was_full || do_pop);
      do_drop   = !fifo_clr && wr_en && !do_push;
      if (fifo_clr) q.delete();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({wr_err, wr_data});
      m_ovr = do_drop;
      if (do_drop) m_sticky = 1'b1;
      else if (ovr_clr) m_sticky = 1'b0;
      if (fifo_clr || do_push || do_pop || was_empty) m_idle = 0;
      else m_idle++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("trig_hit", 32'(trig_hit), 32'(q.size() >= m_trig_lvl(trig_sel)));
      chk("err_pending", 32'(err_pending), 32'(m_err_pending()));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("overrun_sticky", 32'(overrun_sticky), 32'(m_sticky));
      chk("timeout", 32'(timeout),
          32'((tout_cycles != 0) && (q.size() != 0) && (m_idle >= int'(tout_cycles))));
      if (q.size() != 0) begin
        chk("rd_data", 32'(rd_data), 32'(q[0][7:0]));
        chk("rd_err", 32'(rd_err), 32'(q[0][10:8]));
      end
    end
  end

  task automatic step(input logic w, input logic [7:0] d, input logic [2:0] e,
                      input logic r, input logic c, input logic oc);
    wr_en = w; wr_data = d; wr_err = e; rd_en = r; fifo_clr = c; ovr_clr = oc;
    @(posedge clk);
    #2;
    wr_en = 1'b0; rd_en = 1'b0; fifo_clr = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] e);
    step(1'b1, d, e, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; fifo_clr = 1'b0; wr_en = 1'b0; wr_data = '0; wr_err = '0;
    rd_en = 1'b0; trig_sel = 2'd0; tout_cycles = '0; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_on = 1'b1;
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst count", 32'(count), 32'd0);
    chk("rst trig_hit", 32'(trig_hit), 32'd0);
    chk("rst sticky", 32'(overrun_sticky), 32'd0);
    rst = 1'b0;

    // Basic FWFT and error-flag tracking
    push(8'hA5, 3'b000);
    push(8'h3C, 3'b001);
    chk("basic count", 32'(count), 32'd2);
    chk("basic head", 32'(rd_data), 32'hA5);
    chk("basic err_pending", 32'(err_pending), 32'd1);
    pop();
    chk("pop1 data", 32'(rd_data), 32'h3C);
    chk("pop1 err", 32'(rd_err), 32'd1);
    pop();
    chk("pop2 empty", 32'(empty), 32'd1);
    chk("pop2 err_pending", 32'(err_pending), 32'd0);

    // Fill, overflow, sticky behaviour
    for (int i = 0; i < DEPTH; i++) push(8'(i), 3'b000);
    chk("fill full", 32'(full), 32'd1);
    push(8'hFF, 3'b000);
    chk("ovr pulse", 32'(overrun), 32'd1);
    chk("ovr sticky", 32'(overrun_sticky), 32'd1);
    idle(1);
    chk("ovr pulse gone", 32'(overrun), 32'd0);
    chk("ovr head kept", 32'(rd_data), 32'h00);
    step(1'b1, 8'hFE, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("ovr set beats clr", 32'(overrun_sticky), 32'd1);
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(overrun_sticky), 32'd0);

    // Push and pop together while full
    step(1'b1, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("full pp overrun", 32'(overrun), 32'd0);
    chk("full pp count", 32'(count), 32'd16);
    chk("full pp head", 32'(rd_data), 32'h01);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    chk("tail entry", 32'(rd_data), 32'h55);
    pop();
    // Push and pop together while empty: only the push happens
    step(1'b1, 8'h66, 3'b100, 1'b1, 1'b0, 1'b0);
    chk("empty pp count", 32'(count), 32'd1);
    pop();

    // Trigger levels
    trig_sel = 2'd1;
    for (int i = 0; i < 3; i++) push(8'h20 + 8'(i), (i == 1) ? 3'b100 : 3'b000);
    chk("trig 1/3", 32'(trig_hit), 32'd0);
    push(8'h23, 3'b000);
    chk("trig 1/4", 32'(trig_hit), 32'd1);
    trig_sel = 2'd3;
    for (int i = 0; i < 9; i++) push(8'h30 + 8'(i), 3'b010);
    chk("trig 3/13", 32'(trig_hit), 32'd0);
    push(8'h40, 3'b000);
    chk("trig 3/14", 32'(trig_hit), 32'd1);
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
    trig_sel = 2'd0;

    // Character timeout
    tout_cycles = 16'd20;
    push(8'h11, 3'b000);
    idle(19);
    chk("timeout early", 32'(timeout), 32'd0);
    idle(1);
    chk("timeout at 20", 32'(timeout), 32'd1);
    idle(5);
    chk("timeout held", 32'(timeout), 32'd1);
    pop();
    chk("timeout dropped", 32'(timeout), 32'd0);
    tout_cycles = 16'd0;
    push(8'h12, 3'b000);
    idle(40);
    chk("timeout disabled", 32'(timeout), 32'd0);
    pop();

    // Flush keeps the sticky overrun and discards a same-cycle push
    for (int i = 0; i <= DEPTH; i++) push(8'h80 + 8'(i), 3'b000);
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push(8'h90 + 8'(i), (i == 2) ? 3'b011 : 3'b000);
    chk("pre-clr err_pending", 32'(err_pending), 32'd1);
    step(1'b1, 8'hEE, 3'b010, 1'b0, 1'b1, 1'b0);
    chk("clr empty", 32'(empty), 32'd1);
    chk("clr count", 32'(count), 32'd0);
    chk("clr err_pending", 32'(err_pending), 32'd0);
    chk("clr sticky kept", 32'(overrun_sticky), 32'd1);
    push(8'h77, 3'b000);
    chk("post-clr head", 32'(rd_data), 32'h77);
    chk("post-clr count", 32'(count), 32'd1);

    // Reset mid-operation
    push(8'h78, 3'b001);
    push(8'h79, 3'b000);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("mid rst empty", 32'(empty), 32'd1);
    chk("mid rst sticky", 32'(overrun_sticky), 32'd0);
    chk("mid rst err_pending", 32'(err_pending), 32'd0);
    rst = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
